// File: rtl/winograd_input_transform_seq_pkg.sv
// Shared constants and types for the Winograd F(4x4,3x3) input transform.
// Optional feature macro: WINOGRAD_SAT_EN (saturating arithmetic, sticky ovf).
package winograd_pkg;

   localparam int DATA_W   = 32;
   localparam int TILE     = 6;
   localparam int OUT_TILE = 4;

   // B^T coefficients; row k is the vector r_k used by both passes.
   localparam int BT [0:5][0:5] = '{
      '{ 4,  0, -5,  0, 1, 0},
      '{ 0, -4, -4,  1, 1, 0},
      '{ 0,  4, -4, -1, 1, 0},
      '{ 0, -2, -1,  2, 1, 0},
      '{ 0,  2, -1, -2, 1, 0},
      '{ 0,  4,  0, -5, 0, 1}
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROW  = 2'd1,
      COL  = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef logic signed [DATA_W-1:0] elem_t;

endpackage

// File: rtl/winograd_input_transform_seq_if.sv
// Tile handshake bundle between producer, transform block and consumer.
// Handshake: a tile moves on the input side in a cycle where in_valid and
// in_ready are both high; the result is held while out_valid is high and
// retires in the cycle out_ready is seen high. Neither valid may depend on
// the matching ready.
interface winograd_input_transform_seq_if #(parameter int DATA_W = 32);
   logic                           in_valid;
   logic                           in_ready;
   logic [0:5][0:5][DATA_W-1:0]    tile_in;
   logic                           out_valid;
   logic                           out_ready;
   logic [0:5][0:5][DATA_W-1:0]    tile_out;
   logic                           ovf;

   modport master (
      output in_valid, tile_in, out_ready,
      input  in_ready, out_valid, tile_out, ovf
   );

   modport slave (
      input  in_valid, tile_in, out_ready,
      output in_ready, out_valid, tile_out, ovf
   );
endinterface

// File: rtl/winograd_input_transform_seq_dot6.sv
// One row of B^T dotted with a 6-element vector, shift/add only.
module winograd_bt_dot6 #(
   parameter int W = 32
) (
   input  logic [0:5][W-1:0] x,
   input  logic [2:0]        k,
   output logic [W-1:0]      y
);

   logic signed [W-1:0] x0, x1, x2, x3, x4, x5;

   assign x0 = x[0];
   assign x1 = x[1];
   assign x2 = x[2];
   assign x3 = x[3];
   assign x4 = x[4];
   assign x5 = x[5];

   // Select the coefficient row; every constant product is a shift or shift+add.
   always_comb begin
      y = '0;
      case (k)
         3'd0:    y = (x0 <<< 2) - ((x2 <<< 2) + x2) + x4;
         3'd1:    y = x3 + x4 - ((x1 + x2) <<< 2);
         3'd2:    y = ((x1 - x2) <<< 2) - x3 + x4;
         3'd3:    y = ((x3 - x1) <<< 1) - x2 + x4;
         3'd4:    y = ((x1 - x3) <<< 1) - x2 + x4;
         3'd5:    y = (x1 <<< 2) - ((x3 <<< 2) + x3) + x5;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/winograd_input_transform_seq.sv
// Sequential Winograd input transform V = B^T d B: a row pass producing T one
// row per cycle, then a column pass producing V one column per cycle.
// Optional feature macro: WINOGRAD_SAT_EN (DATA_W+4 internal width, clamp, ovf).
module winograd_input_transform_seq
   import winograd_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   winograd_input_transform_seq_if.slave bus,
   output state_e                        dbg_state
);

`ifdef WINOGRAD_SAT_EN
   localparam int IW = DATA_W + 4;
   localparam logic signed [IW-1:0] MAXV = {{5{1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [IW-1:0] MINV = {{5{1'b1}}, {(DATA_W-1){1'b0}}};
`else
   localparam int IW = DATA_W;
`endif

   state_e                        state_q, state_d;
   logic [2:0]                    k_q, k_d;
   logic [0:5][0:5][DATA_W-1:0]   d_q, d_d;
   logic [0:5][0:5][DATA_W-1:0]   t_q, t_d;
   logic [0:5][0:5][DATA_W-1:0]   v_q, v_d;
   logic                          in_ready_q, in_ready_d;
   logic                          out_valid_q, out_valid_d;
   logic                          ovf_q, ovf_d;

   logic [0:5][IW-1:0]            dot_x [6];
   logic [IW-1:0]                 dot_y [6];
   logic [DATA_W-1:0]             nar   [6];
   logic [5:0]                    clamp;

   // Row pass feeds column c of d to copy c; column pass feeds row c of T.
   always_comb begin
      for (int c = 0; c < 6; c++) begin
         for (int e = 0; e < 6; e++) begin
            if (state_q == COL) dot_x[c][e] = IW'($signed(t_q[c][e]));
            else                dot_x[c][e] = IW'($signed(d_q[e][c]));
         end
      end
   end

   for (genvar g = 0; g < 6; g++) begin : g_dot
      winograd_bt_dot6 #(.W(IW)) u_dot (
         .x (dot_x[g]),
         .k (k_q),
         .y (dot_y[g])
      );
   end

   // Bring each dot result back to DATA_W: clamp when saturating, else wrap.
   always_comb begin
      for (int c = 0; c < 6; c++) begin
`ifdef WINOGRAD_SAT_EN
         if ($signed(dot_y[c]) > MAXV) begin
            nar[c]   = MAXV[DATA_W-1:0];
            clamp[c] = 1'b1;
         end else if ($signed(dot_y[c]) < MINV) begin
            nar[c]   = MINV[DATA_W-1:0];
            clamp[c] = 1'b1;
         end else begin
            nar[c]   = dot_y[c][DATA_W-1:0];
            clamp[c] = 1'b0;
         end
`else
         nar[c]   = dot_y[c];
         clamp[c] = 1'b0;
`endif
      end
   end

   // Next-state logic: capture in IDLE, 6 row cycles, 6 column cycles, hold in DONE.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      d_d         = d_q;
      t_d         = t_q;
      v_d         = v_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      ovf_d       = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               d_d        = bus.tile_in;
               k_d        = 3'd0;
               ovf_d      = 1'b0;
               in_ready_d = 1'b0;
               state_d    = ROW;
            end
         end
         ROW: begin
            for (int c = 0; c < 6; c++) t_d[k_q][c] = nar[c];
            ovf_d = ovf_q | (|clamp);
            if (k_q == 3'd5) begin
               k_d     = 3'd0;
               state_d = COL;
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         COL: begin
            for (int c = 0; c < 6; c++) v_d[c][k_q] = nar[c];
            ovf_d = ovf_q | (|clamp);
            if (k_q == 3'd5) begin
               k_d         = 3'd0;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial tile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= 3'd0;
         d_q         <= '0;
         t_q         <= '0;
         v_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         d_q         <= d_d;
         t_q         <= t_d;
         v_q         <= v_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.tile_out  = v_q;
   assign bus.ovf       = ovf_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_winograd_input_transform_seq.sv
// Directed bench for winograd_input_transform_seq: reset, unit tiles,
// backpressure, mid-operation reset, a 3x3 sweep of image tiles and overflow.
module tb_winograd_input_transform_seq;
   import winograd_pkg::*;

   typedef logic [0:5][0:5][31:0] tile_t;

   logic   clk;
   logic   rst_n;
   state_e dbg_state;
   int     n_vec;
   int     n_bad;
   int     cyc;

   int bt [0:5][0:5] = '{
      '{ 4,  0, -5,  0, 1, 0},
      '{ 0, -4, -4,  1, 1, 0},
      '{ 0,  4, -4, -1, 1, 0},
      '{ 0, -2, -1,  2, 1, 0},
      '{ 0,  2, -1, -2, 1, 0},
      '{ 0,  4,  0, -5, 0, 1}
   };

   winograd_input_transform_seq_if #(.DATA_W(32)) bus ();

   winograd_input_transform_seq #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_tile(input string tag, input tile_t exp);
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            check($sformatf("%s V[%0d][%0d]", tag, i, j), bus.tile_out[i][j], exp[i][j]);
   endtask

   // Reference B^T d B in 64-bit, truncated to 32 bits at the end.
   function automatic tile_t ref_v(input tile_t d);
      longint t [6][6];
      longint acc;
      tile_t  v;
      for (int k = 0; k < 6; k++)
         for (int j = 0; j < 6; j++) begin
            acc = 0;
            for (int i = 0; i < 6; i++) acc += longint'(bt[k][i]) * longint'($signed(d[i][j]));
            t[k][j] = acc;
         end
      for (int i = 0; i < 6; i++)
         for (int k = 0; k < 6; k++) begin
            acc = 0;
            for (int j = 0; j < 6; j++) acc += longint'(bt[k][j]) * t[i][j];
            v[i][k] = acc[31:0];
         end
      return v;
   endfunction

   // Tile (ti,tj) of the 10x12 image with one ring of zero padding.
   function automatic tile_t img_tile(input int ti, input int tj);
      tile_t t;
      int    r, c;
      for (int a = 0; a < 6; a++)
         for (int b = 0; b < 6; b++) begin
            r = 4 * ti + a - 1;
            c = 4 * tj + b - 1;
            if (r >= 0 && r < 10 && c >= 0 && c < 12) t[a][b] = 32'(r * 12 + c + 1);
            else                                       t[a][b] = 32'd0;
         end
      return t;
   endfunction

   // Called at a negedge; drives one accepted handshake, returns at the next negedge.
   task automatic send(input string tag, input tile_t t);
      check({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      bus.tile_in  = t;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.tile_in  = '0;
   endtask

   task automatic wait_valid(input string tag);
      cyc = 0;
      while (!bus.out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'd12);
   endtask

   task automatic release_out(input string tag);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, " out_valid after ready"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, " in_ready after ready"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   tile_t ones, d00, d55, big, e_ones, e_d00, e_d55, e_big, zero_t;

   initial begin
      n_vec = 0;
      n_bad = 0;
      zero_t = '0;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) ones[i][j] = 32'd1;
      d00 = '0; d00[0][0] = 32'd1;
      d55 = '0; d55[5][5] = 32'd1;
      big = '0; big[0][0] = 32'h4000_0000;
      e_ones = '0; e_ones[1][1] = 32'd36;
      e_d00  = '0; e_d00[0][0]  = 32'd16;
      e_d55  = '0; e_d55[5][5]  = 32'd1;
      e_big  = '0;
`ifdef WINOGRAD_SAT_EN
      e_big[0][0] = 32'h7FFF_FFFF;
`endif

      // reset
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.tile_in   = '0;
      repeat (3) @(negedge clk);
      check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset ovf", {31'd0, bus.ovf}, 32'd0);
      check("reset state", 32'(dbg_state), 32'(IDLE));
      check_tile("reset", zero_t);
      rst_n = 1'b1;
      @(negedge clk);

      // all-ones tile
      send("ones", ones);
      wait_valid("ones");
      check_tile("ones", e_ones);
      check("ones ovf", {31'd0, bus.ovf}, 32'd0);
      release_out("ones");

      // d[0][0]=1 with 20 cycles of backpressure and an ignored second offer
      send("d00", d00);
      wait_valid("d00");
      bus.tile_in  = ones;
      bus.in_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         check($sformatf("bp in_ready c%0d", n), {31'd0, bus.in_ready}, 32'd0);
         check($sformatf("bp out_valid c%0d", n), {31'd0, bus.out_valid}, 32'd1);
         check($sformatf("bp V00 c%0d", n), bus.tile_out[0][0], 32'd16);
      end
      bus.in_valid = 1'b0;
      bus.tile_in  = '0;
      check_tile("d00", e_d00);
      release_out("d00");

      // d[5][5]=1, with out_ready held high while computing
      bus.out_ready = 1'b1;
      send("d55", d55);
      wait_valid("d55");
      check_tile("d55", e_d55);
      release_out("d55");

      // reset during COL k=3: asynchronous clear
      send("rst", ones);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("midrst state", 32'(dbg_state), 32'(IDLE));
      check_tile("midrst", zero_t);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send("ones2", ones);
      wait_valid("ones2");
      check_tile("ones2", e_ones);
      release_out("ones2");

      // 3x3 sweep of the sequential image, issued back to back
      for (int ti = 0; ti < 3; ti++)
         for (int tj = 0; tj < 3; tj++) begin
            bus.out_ready = 1'b1;
            send($sformatf("img%0d%0d", ti, tj), img_tile(ti, tj));
            wait_valid($sformatf("img%0d%0d", ti, tj));
            check_tile($sformatf("img%0d%0d", ti, tj), ref_v(img_tile(ti, tj)));
            release_out($sformatf("img%0d%0d", ti, tj));
         end

      // overflow: wrap in the default build, clamp with sticky ovf when saturating
      send("big", big);
      wait_valid("big");
      check_tile("big", e_big);
`ifdef WINOGRAD_SAT_EN
      check("big ovf", {31'd0, bus.ovf}, 32'd1);
`else
      check("big ovf", {31'd0, bus.ovf}, 32'd0);
`endif
      release_out("big");

      // ovf cleared on the next accepted tile
      send("after big", d00);
      wait_valid("after big");
      check("after big ovf", {31'd0, bus.ovf}, 32'd0);
      check_tile("after big", e_d00);
      release_out("after big");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
